mem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the byte-serial memory controller.
- Shares the controller between instruction fetch (IF, read-only) and the load/store unit (LSU).
- Owns one outstanding transaction at a time and routes the controller result back to the owner.
- LSU has priority, with an IF starvation guard; in-flight fetches can be cancelled on pipeline flush.

---
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the IF/LSU requesters, the arbiter and the byte-serial memory controller.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              if_valid;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_done;
  logic [31:0]       if_rdata;

  logic              lsu_valid;
  logic [1:0]        lsu_op;
  logic [1:0]        lsu_len;
  logic [ADDR_W-1:0] lsu_addr;
  logic [31:0]       lsu_wdata;
  logic              lsu_done;
  logic [31:0]       lsu_rdata;

  logic              ctl_valid;
  logic [1:0]        ctl_op;
  logic [1:0]        ctl_len;
  logic [ADDR_W-1:0] ctl_addr;
  logic [31:0]       ctl_data;
  logic              ctl_done;
  logic [31:0]       ctl_rdata;

  logic              busy;

  modport slave (
    input  if_valid, if_addr, if_flush,
    input  lsu_valid, lsu_op, lsu_len, lsu_addr, lsu_wdata,
    input  ctl_done, ctl_rdata,
    output if_done, if_rdata, lsu_done, lsu_rdata,
    output ctl_valid, ctl_op, ctl_len, ctl_addr, ctl_data, busy
  );

  modport master (
    output if_valid, if_addr, if_flush,
    output lsu_valid, lsu_op, lsu_len, lsu_addr, lsu_wdata,
    output ctl_done, ctl_rdata,
    input  if_done, if_rdata, lsu_done, lsu_rdata,
    input  ctl_valid, ctl_op, ctl_len, ctl_addr, ctl_data, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (IF / LSU) arbiter in front of the memory controller: one transaction at a time,
// LSU priority with an IF starvation guard, and cancellation of in-flight fetches on flush.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  mem_arbiter_if.slave  bus
);
  localparam logic [1:0] OpLoad  = 2'b01;
  localparam logic [1:0] OpSave  = 2'b10;
  localparam logic [1:0] LenWord = 2'b10;
  localparam logic [3:0] Limit   = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e            state_q, state_d;
  logic              owner_if_q, owner_if_d;
  logic              cancel_q, cancel_d;
  logic [3:0]        starve_q, starve_d;
  logic [1:0]        op_q, op_d;
  logic [1:0]        len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       lsu_rdata_q, lsu_rdata_d;

  logic       lsu_req, if_req, grant_if, in_busy, if_done_w, lsu_done_w;
  logic [1:0] lsu_len_n;

  function automatic logic [31:0] mask_len(input logic [31:0] v, input logic [1:0] len);
    case (len)
      2'b00:   mask_len = {24'd0, v[7:0]};
      2'b01:   mask_len = {16'd0, v[15:0]};
      default: mask_len = v;
    endcase
  endfunction

  assign lsu_req   = bus.lsu_valid & ((bus.lsu_op == OpLoad) | (bus.lsu_op == OpSave));
  assign if_req    = bus.if_valid & ~bus.if_flush;
  assign lsu_len_n = (bus.lsu_len == 2'b11) ? LenWord : bus.lsu_len;
  assign in_busy   = (state_q == StBusy);

  // A flush arriving in the RESP cycle itself still has to swallow that cycle's if_done.
  assign if_done_w  = (state_q == StResp) & owner_if_q & ~cancel_q & ~(rdy_in & bus.if_flush);
  assign lsu_done_w = (state_q == StResp) & ~owner_if_q;

  assign bus.if_done   = if_done_w;
  assign bus.lsu_done  = lsu_done_w;
  assign bus.if_rdata  = if_done_w ? rdata_q : if_rdata_q;
  assign bus.lsu_rdata = (lsu_done_w && op_q == OpLoad) ? rdata_q : lsu_rdata_q;
  assign bus.ctl_valid = in_busy;
  assign bus.ctl_op    = in_busy ? op_q : 2'b00;
  assign bus.ctl_len   = in_busy ? len_q : 2'b00;
  assign bus.ctl_addr  = in_busy ? addr_q : '0;
  assign bus.ctl_data  = in_busy ? data_q : 32'd0;
  assign bus.busy      = (state_q != StIdle);

  always_comb begin
    state_d     = state_q;
    owner_if_d  = owner_if_q;
    cancel_d    = cancel_q;
    starve_d    = starve_q;
    op_d        = op_q;
    len_d       = len_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rdata_d     = rdata_q;
    if_rdata_d  = if_rdata_q;
    lsu_rdata_d = lsu_rdata_q;
    grant_if    = 1'b0;

    if (rdy_in) begin
      unique case (state_q)
        StIdle: begin
          if (lsu_req || if_req) begin
            grant_if   = if_req & (~lsu_req | (starve_q == Limit));
            state_d    = StBusy;
            owner_if_d = grant_if;
            cancel_d   = 1'b0;
            if (grant_if) begin
              op_d     = OpLoad;
              len_d    = LenWord;
              addr_d   = bus.if_addr;
              data_d   = 32'd0;
              starve_d = 4'd0;
            end else begin
              op_d     = bus.lsu_op;
              len_d    = lsu_len_n;
              addr_d   = bus.lsu_addr;
              data_d   = (bus.lsu_op == OpSave) ? mask_len(bus.lsu_wdata, lsu_len_n) : 32'd0;
              starve_d = !if_req ? 4'd0 : (starve_q == Limit) ? starve_q : starve_q + 4'd1;
            end
          end else begin
            starve_d = 4'd0;
          end
        end
        StBusy: begin
          if (owner_if_q && bus.if_flush) cancel_d = 1'b1;
          if (bus.ctl_done) begin
            rdata_d = mask_len(bus.ctl_rdata, len_q);
            state_d = StResp;
          end
        end
        StResp: begin
          state_d     = StIdle;
          cancel_d    = 1'b0;
          if_rdata_d  = bus.if_rdata;
          lsu_rdata_d = bus.lsu_rdata;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      owner_if_q  <= 1'b0;
      cancel_q    <= 1'b0;
      starve_q    <= 4'd0;
      op_q        <= 2'b00;
      len_q       <= 2'b00;
      addr_q      <= '0;
      data_q      <= 32'd0;
      rdata_q     <= 32'd0;
      if_rdata_q  <= 32'd0;
      lsu_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      owner_if_q  <= owner_if_d;
      cancel_q    <= cancel_d;
      starve_q    <= starve_d;
      op_q        <= op_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rdata_q     <= rdata_d;
      if_rdata_q  <= if_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected completions are queued when requests are driven and
// popped whenever a done pulse appears; a small negedge model plays the memory controller.
module tb_mem_arbiter;
  localparam int unsigned ADDR_W = 32;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  always #5 clk_in = ~clk_in;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_arbiter #(.STARVE_LIMIT(4), .ADDR_W(ADDR_W)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  typedef struct packed {
    logic        is_if;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic        auto_ctl = 1'b0;
  int          lat = 5;
  int          cnt = 0;
  logic        done_auto = 1'b0;
  logic        done_man = 1'b0;
  logic [31:0] ctl_rdata_v = 32'd0;
  logic [31:0] last_if = 32'd0;
  logic [31:0] last_lsu = 32'd0;

  assign bus.ctl_done  = done_auto | done_man;
  assign bus.ctl_rdata = ctl_rdata_v;

  // Controller model: completes lat cycles after ctl_valid first appears.
  always @(negedge clk_in) begin
    if (auto_ctl && bus.ctl_valid && !done_auto) begin
      if (cnt + 1 >= lat) begin
        done_auto <= 1'b1;
        cnt       <= 0;
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      done_auto <= 1'b0;
      if (!bus.ctl_valid) cnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk_in);
    #1;
    if (bus.if_done || bus.lsu_done) begin
      check("one_done", 32'(bus.if_done & bus.lsu_done), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("done_owner", 32'(bus.if_done), 32'(e.is_if));
        check("done_rdata", e.is_if ? bus.if_rdata : bus.lsu_rdata, e.data);
      end
    end
  endtask

  task automatic wait_sb(input int max);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max) begin
      tick();
      n++;
    end
    check("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic lsu_req(input logic [1:0] op, input logic [1:0] len, input logic [31:0] addr,
                         input logic [31:0] wdata);
    bus.lsu_valid = 1'b1;
    bus.lsu_op    = op;
    bus.lsu_len   = len;
    bus.lsu_addr  = addr;
    bus.lsu_wdata = wdata;
  endtask

  initial begin
    int vcnt;
    rst_in        = 1'b1;
    rdy_in        = 1'b1;
    bus.if_valid  = 1'b0;
    bus.if_addr   = '0;
    bus.if_flush  = 1'b0;
    bus.lsu_valid = 1'b0;
    bus.lsu_op    = 2'b00;
    bus.lsu_len   = 2'b00;
    bus.lsu_addr  = '0;
    bus.lsu_wdata = 32'd0;

    tick();
    tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ctl_valid", 32'(bus.ctl_valid), 32'd0);
    check("rst_if_done", 32'(bus.if_done), 32'd0);
    check("rst_lsu_done", 32'(bus.lsu_done), 32'd0);
    check("rst_if_rdata", bus.if_rdata, 32'd0);
    check("rst_lsu_rdata", bus.lsu_rdata, 32'd0);
    check("rst_ctl_addr", bus.ctl_addr, 32'd0);
    check("rst_ctl_data", bus.ctl_data, 32'd0);
    rst_in = 1'b0;
    tick();

    // Single fetch, controller answers after ctl_valid has been up 5 cycles.
    auto_ctl     = 1'b1;
    lat          = 5;
    ctl_rdata_v  = 32'hDEADBEEF;
    bus.if_valid = 1'b1;
    bus.if_addr  = 32'h100;
    sb.push_back('{1'b1, 32'hDEADBEEF});
    last_if = 32'hDEADBEEF;
    tick();
    check("f_ctl_valid_c1", 32'(bus.ctl_valid), 32'd1);
    check("f_ctl_op", 32'(bus.ctl_op), 32'd1);
    check("f_ctl_len", 32'(bus.ctl_len), 32'd2);
    check("f_ctl_addr", bus.ctl_addr, 32'h100);
    check("f_ctl_data", bus.ctl_data, 32'd0);
    vcnt = 0;
    for (int c = 2; c <= 5; c++) begin
      tick();
      if (bus.ctl_valid) vcnt++;
    end
    check("f_valid_c2_5", 32'(vcnt), 32'd4);
    tick();
    check("f_if_done_c6", 32'(bus.if_done), 32'd1);
    check("f_ctl_valid_c6", 32'(bus.ctl_valid), 32'd0);
    bus.if_valid = 1'b0;
    tick();
    check("f_idle_c7", 32'(bus.busy), 32'd0);

    // Half and byte loads, then a word store.
    lat         = 3;
    ctl_rdata_v = 32'h12348765;
    lsu_req(2'b01, 2'b01, 32'h40, 32'd0);
    sb.push_back('{1'b0, 32'h00008765});
    last_lsu = 32'h00008765;
    wait_sb(20);
    bus.lsu_valid = 1'b0;
    tick();
    ctl_rdata_v = 32'hA5A55A3C;
    lsu_req(2'b01, 2'b00, 32'h41, 32'd0);
    sb.push_back('{1'b0, 32'h0000003C});
    last_lsu = 32'h0000003C;
    wait_sb(20);
    bus.lsu_valid = 1'b0;
    tick();
    ctl_rdata_v = 32'hFFFFFFFF;
    lsu_req(2'b10, 2'b10, 32'h20, 32'hCAFEF00D);
    sb.push_back('{1'b0, last_lsu});
    tick();
    check("st_ctl_data", bus.ctl_data, 32'hCAFEF00D);
    check("st_ctl_op", 32'(bus.ctl_op), 32'd2);
    check("st_ctl_addr", bus.ctl_addr, 32'h20);
    wait_sb(20);
    check("st_lsu_done", 32'(bus.lsu_done), 32'd1);
    check("st_if_done", 32'(bus.if_done), 32'd0);
    bus.lsu_valid = 1'b0;
    tick();

    // Contention: expect L,L,L,L,I,L,L,L,L,I.
    lat          = 2;
    ctl_rdata_v  = 32'h0BADF00D;
    bus.if_valid = 1'b1;
    bus.if_addr  = 32'h200;
    lsu_req(2'b01, 2'b10, 32'h300, 32'd0);
    for (int i = 0; i < 10; i++) sb.push_back('{(i % 5) == 4, 32'h0BADF00D});
    wait_sb(300);
    bus.if_valid  = 1'b0;
    bus.lsu_valid = 1'b0;
    last_if  = 32'h0BADF00D;
    last_lsu = 32'h0BADF00D;
    tick();

    // Flush in IDLE suppresses the request; flush in BUSY cancels the fetch.
    auto_ctl     = 1'b0;
    bus.if_valid = 1'b1;
    bus.if_addr  = 32'h400;
    bus.if_flush = 1'b1;
    tick();
    check("fl_idle_nogrant", 32'(bus.busy), 32'd0);
    bus.if_flush = 1'b0;
    tick();
    check("fl_grant", 32'(bus.busy), 32'd1);
    check("fl_ctl_addr", bus.ctl_addr, 32'h400);
    lsu_req(2'b01, 2'b10, 32'h500, 32'd0);
    sb.push_back('{1'b0, 32'h22222222});
    tick();
    bus.if_flush = 1'b1;
    bus.if_valid = 1'b0;
    tick();
    bus.if_flush = 1'b0;
    tick();
    ctl_rdata_v = 32'h11111111;
    done_man    = 1'b1;
    tick();
    done_man = 1'b0;
    check("fl_no_if_done", 32'(bus.if_done), 32'd0);
    check("fl_if_rdata_kept", bus.if_rdata, last_if);
    tick();
    check("fl_idle", 32'(bus.busy), 32'd0);
    tick();
    check("fl_lsu_addr", bus.ctl_addr, 32'h500);
    ctl_rdata_v = 32'h22222222;
    done_man    = 1'b1;
    tick();
    done_man = 1'b0;
    check("fl_lsu_served", 32'(sb.size()), 32'd0);
    bus.lsu_valid = 1'b0;
    last_lsu      = 32'h22222222;
    tick();

    // rdy_in low for 3 cycles in BUSY, ctl_done pulsing mid-stall.
    lsu_req(2'b01, 2'b10, 32'h600, 32'd0);
    sb.push_back('{1'b0, 32'h44444444});
    tick();
    check("rdy_busy", 32'(bus.ctl_valid), 32'd1);
    rdy_in      = 1'b0;
    ctl_rdata_v = 32'h33333333;
    tick();
    check("rdy_stall1", 32'(bus.ctl_valid), 32'd1);
    done_man = 1'b1;
    tick();
    done_man = 1'b0;
    check("rdy_stall2", 32'(bus.ctl_valid), 32'd1);
    tick();
    check("rdy_stall3_nodone", 32'(bus.lsu_done), 32'd0);
    rdy_in = 1'b1;
    tick();
    check("rdy_still_busy", 32'(bus.ctl_valid), 32'd1);
    check("rdy_addr_kept", bus.ctl_addr, 32'h600);
    ctl_rdata_v = 32'h44444444;
    done_man    = 1'b1;
    tick();
    done_man = 1'b0;
    check("rdy_lsu_done", 32'(bus.lsu_done), 32'd1);
    bus.lsu_valid = 1'b0;
    tick();

    // Reset during BUSY abandons the fetch; a later request is served normally.
    bus.if_valid = 1'b1;
    bus.if_addr  = 32'h700;
    tick();
    check("rb_busy", 32'(bus.busy), 32'd1);
    rst_in = 1'b1;
    tick();
    check("rb_ctl_valid", 32'(bus.ctl_valid), 32'd0);
    check("rb_busy_low", 32'(bus.busy), 32'd0);
    check("rb_if_rdata", bus.if_rdata, 32'd0);
    check("rb_lsu_rdata", bus.lsu_rdata, 32'd0);
    rst_in = 1'b0;
    sb.push_back('{1'b1, 32'h55555555});
    tick();
    check("rb_regrant", 32'(bus.busy), 32'd1);
    check("rb_ctl_addr", bus.ctl_addr, 32'h700);
    ctl_rdata_v = 32'h55555555;
    done_man    = 1'b1;
    tick();
    done_man     = 1'b0;
    bus.if_valid = 1'b0;
    tick();
    check("end_idle", 32'(bus.busy), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
